// File: rtl/inst_fetch.sv
// Instruction fetch: drives ROM byte addresses, tracks the 1-cycle ROM read, hands words to decode (FETCH_FAULT_CHECK_EN adds fault check).
// Latency: first instruction 1 cycle after reset release; redirect costs 1 bubble; 1 instr/cycle sustained.
// Backpressure: inst_valid & ~inst_ready re-reads the held word so rom_data stays stable; redirect overrides hold.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        fetch_fault
);

`ifdef FETCH_FAULT_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam logic [32:0] ROM_BYTES = 33'd1 << (ADDR_WIDTH + 2);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic        fault_q;
  logic        hold;
  logic        redirect_bad;

  assign hold         = resp_valid & ~inst_ready;
  assign redirect_bad = (redirect_target[1:0] != 2'b00) ||
                        ({1'b0, redirect_target} >= ROM_BYTES);

  // Holding re-presents resp_pc to the ROM so the registered read returns the same word.
  assign rom_addr    = hold ? resp_pc : fetch_pc;
  assign inst_out    = rom_data;
  assign pc_out      = resp_pc;
  assign inst_valid  = resp_valid;
  assign fetch_fault = fault_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= 32'h0;
      resp_valid <= 1'b0;
      fault_q    <= 1'b0;
    end else if (redirect_valid) begin
      // The word currently being read belongs to the old path and is dropped.
      fetch_pc   <= {redirect_target[31:2], 2'b00};
      resp_valid <= 1'b0;
      fault_q    <= fault_q | (FAULT_EN & redirect_bad);
    end else if (!hold) begin
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      fetch_pc   <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus a hand-written back-pressure stream.
module tb_inst_fetch;

`ifdef FETCH_FAULT_CHECK_EN
  localparam logic FEN = 1'b1;
`else
  localparam logic FEN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        fetch_fault;

  always #5 clock = ~clock;

  inst_fetch #(.RESET_PC(32'h0), .ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .inst_valid(inst_valid),
    .inst_out(inst_out), .pc_out(pc_out), .fetch_fault(fetch_fault)
  );

  // ROM model: word i holds i, registered read, zero while in reset.
  logic [31:0] rom_mem [0:255];
  initial for (int i = 0; i < 256; i++) rom_mem[i] = i;
  always @(posedge clock) begin
    if (reset) rom_data <= 32'h0;
    else       rom_data <= rom_mem[rom_addr[9:2]];
  end

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] tgt;
    logic        ev, cd;
    logic [31:0] pc, inst, addr;
    logic        fl;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt,
                     input logic ev, input logic cd, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] addr, input logic fl);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.tgt = tgt; v.ev = ev; v.cd = cd;
    v.pc = pc; v.inst = inst; v.addr = addr; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          w;

    // rst rdy rv tgt | valid chkdata pc inst addr fault
    add(1, 1, 0, 0,            0, 1, 32'h00, 0,   32'h00, 0);
    add(1, 1, 0, 0,            0, 1, 32'h00, 0,   32'h00, 0);
    add(0, 1, 0, 0,            0, 1, 32'h00, 0,   32'h00, 0);
    add(0, 1, 0, 0,            1, 1, 32'h00, 0,   32'h04, 0);
    add(0, 1, 0, 0,            1, 1, 32'h04, 1,   32'h08, 0);
    add(0, 0, 0, 0,            1, 1, 32'h08, 2,   32'h08, 0);
    add(0, 0, 0, 0,            1, 1, 32'h08, 2,   32'h08, 0);
    add(0, 0, 0, 0,            1, 1, 32'h08, 2,   32'h08, 0);
    add(0, 1, 0, 0,            1, 1, 32'h08, 2,   32'h0C, 0);
    add(0, 1, 0, 0,            1, 1, 32'h0C, 3,   32'h10, 0);
    add(0, 1, 1, 32'h40,       1, 1, 32'h10, 4,   32'h14, 0);
    add(0, 1, 0, 0,            0, 0, 0,      0,   32'h40, 0);
    add(0, 1, 0, 0,            1, 1, 32'h40, 16,  32'h44, 0);
    add(0, 1, 0, 0,            1, 1, 32'h44, 17,  32'h48, 0);
    add(0, 0, 1, 32'h80,       1, 1, 32'h48, 18,  32'h48, 0);
    add(0, 1, 0, 0,            0, 0, 0,      0,   32'h80, 0);
    add(0, 1, 0, 0,            1, 1, 32'h80, 32,  32'h84, 0);
    add(0, 0, 0, 0,            1, 1, 32'h84, 33,  32'h84, 0);
    add(1, 0, 0, 0,            1, 1, 32'h84, 33,  32'h84, 0);
    add(0, 1, 0, 0,            0, 1, 32'h00, 0,   32'h00, 0);
    add(0, 1, 0, 0,            1, 1, 32'h00, 0,   32'h04, 0);
    add(0, 1, 0, 0,            1, 1, 32'h04, 1,   32'h08, 0);
    add(0, 1, 1, 32'h42,       1, 1, 32'h08, 2,   32'h0C, 0);
    add(0, 1, 0, 0,            0, 0, 0,      0,   32'h40, FEN);
    add(0, 1, 0, 0,            1, 1, 32'h40, 16,  32'h44, FEN);
    add(0, 1, 0, 0,            1, 1, 32'h44, 17,  32'h48, FEN);
    add(0, 1, 1, 32'hFFFFFFFC, 1, 1, 32'h48, 18,  32'h4C, FEN);
    add(0, 1, 0, 0,            0, 0, 0,      0,   32'hFFFFFFFC, FEN);
    add(0, 1, 0, 0,            1, 1, 32'hFFFFFFFC, 255, 32'h00, FEN);
    add(0, 1, 0, 0,            1, 1, 32'h00, 0,   32'h04, FEN);
    add(1, 1, 0, 0,            1, 1, 32'h04, 1,   32'h08, FEN);
    add(0, 1, 0, 0,            0, 1, 32'h00, 0,   32'h00, 0);

    reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    tick; tick;

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; inst_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rv; redirect_target = vecs[i].tgt;
      #1;
      check($sformatf("v%0d.valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].ev});
      check($sformatf("v%0d.rom_addr", i), rom_addr, vecs[i].addr);
      check($sformatf("v%0d.fault", i), {31'h0, fetch_fault}, {31'h0, vecs[i].fl});
      if (vecs[i].cd) begin
        check($sformatf("v%0d.pc", i), pc_out, vecs[i].pc);
        check($sformatf("v%0d.inst", i), inst_out, vecs[i].inst);
      end
      tick;
    end

    // Stream with irregular back-pressure: every pc delivered once, in order, no gaps.
    reset = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    tick;
    redirect_valid = 1'b0;
    w = 0;
    while (inst_valid !== 1'b1 && w < 10) begin
      tick;
      w++;
    end
    check("stream.start_timeout", w, w < 10 ? w : 0);
    exp_pc = 32'h100;
    for (int c = 0; c < 24; c++) begin
      inst_ready = (c % 3) != 1;
      #1;
      check($sformatf("s%0d.valid", c), {31'h0, inst_valid}, 32'h1);
      check($sformatf("s%0d.pc", c), pc_out, exp_pc);
      check($sformatf("s%0d.inst", c), inst_out, exp_pc >> 2);
      if (inst_ready) exp_pc = exp_pc + 32'd4;
      tick;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
